// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

  // Control FSM for bit-serial arithmetic units.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // A counter is never narrower than one bit, even for the smallest legal width.
  localparam int CNT_W_MIN = 1;

  // Bit-counter width for a given operand width: clog2(width), at least CNT_W_MIN.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? CNT_W_MIN : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder, truth-table style (companion of the behavioural full subtractor).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: a, b, c - addend bits and carry-in; sum, carry - result bit and carry-out.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  always_comb begin
    sum   = 1'b0;
    carry = 1'b0;
    case ({a, b, c})
      3'b000: begin sum = 1'b0; carry = 1'b0; end
      3'b001: begin sum = 1'b1; carry = 1'b0; end
      3'b010: begin sum = 1'b1; carry = 1'b0; end
      3'b011: begin sum = 1'b0; carry = 1'b1; end
      3'b100: begin sum = 1'b1; carry = 1'b0; end
      3'b101: begin sum = 1'b0; carry = 1'b1; end
      3'b110: begin sum = 1'b0; carry = 1'b1; end
      3'b111: begin sum = 1'b1; carry = 1'b1; end
      default: begin sum = 1'b0; carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency: start accepted at edge 0 -> WIDTH shift cycles -> done pulse in cycle WIDTH+1.
// Backpressure: start is ignored while busy; a new start is taken in IDLE or on the done cycle.
// Ports: clk, rst (sync, active-high); start/a/b/cin request; busy, done, sum, cout status/result.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    count;
  logic             load;
  logic             last;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] psum_next;

  full_adder_bit u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
  assign psum_next = {fa_s, psum[WIDTH-1:1]};
  assign last      = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          next_state = SHIFT;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      count <= '0;
      psum  <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      psum  <= psum_next;
      carry <= fa_c;
      // Hold the counter on the final bit so it never wraps; load clears it.
      if (!last) begin
        count <= count + CW'(1);
      end
      // Commit on the edge that enters DONE so the result is visible with done.
      if (last) begin
        sum  <= psum_next;
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;
  localparam int BUDGET = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int passes = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns in cycle 1 of the operation.
  task automatic launch(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    a = ai; b = bi; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Step until done is seen (bounded); cyc counts cycles from the accepting edge.
  task automatic wait_done(inout int cyc, output int busy_cycles);
    busy_cycles = 0;
    while (!done && cyc < BUDGET) begin
      if (busy) busy_cycles++;
      step();
      cyc++;
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    step(); step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    else passes++;
  endtask

  task automatic test_basic();
    int cyc = 1;
    int bc;
    logic [W:0] exp = ref_add(8'h35, 8'h4A, 1'b0);
    launch(8'h35, 8'h4A, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if (bc !== 8) $display("FAIL basic_busy_len: got %0d cycles, want 8", bc);
    else passes++;
    checks++;
    if (cyc !== W + 1 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done_cycle: cycle %0d done=%b busy=%b, want %0d 1 0", cyc, done, busy, W + 1);
    else passes++;
    checks++;
    if ({cout, sum} !== exp || exp !== 9'h07F)
      $display("FAIL basic_result: got %b_%h, want %b_%h", cout, sum, exp[W], exp[W-1:0]);
    else passes++;
    step();
    checks++;
    if (done !== 1'b0 || sum !== 8'h7F)
      $display("FAIL basic_pulse_hold: done=%b sum=%h, want 0 7f", done, sum);
    else passes++;
  endtask

  task automatic test_carry();
    logic [W-1:0] va [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [W-1:0] vb [3] = '{8'h01, 8'h00, 8'h80};
    logic         vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [W:0]   want [3] = '{9'h100, 9'h100, 9'h101};
    for (int i = 0; i < 3; i++) begin
      int cyc = 1;
      int bc;
      launch(va[i], vb[i], vc[i]);
      wait_done(cyc, bc);
      checks++;
      if (done !== 1'b1 || {cout, sum} !== want[i])
        $display("FAIL carry_%0d: done=%b got %b_%h, want 1 %b_%h", i, done, cout, sum, want[i][W], want[i][W-1:0]);
      else passes++;
      step();
    end
  endtask

  task automatic test_ignore_busy();
    int cyc = 1;
    int bc;
    int extra = 0;
    launch(8'h10, 8'h20, 1'b0);
    step(); cyc++;
    step(); cyc++;
    // cycle 3: a stray request while busy
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    wait_done(cyc, bc);
    checks++;
    if (done !== 1'b1 || cyc !== W + 1 || {cout, sum} !== 9'h030)
      $display("FAIL ignore_busy_result: cycle %0d done=%b got %b_%h, want %0d 1 0_30", cyc, done, cout, sum, W + 1);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) $display("FAIL ignore_busy_single_done: %0d extra done pulses, want 0", extra);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    launch(8'h0F, 8'h01, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
      $display("FAIL reset_mid_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0", busy, done, sum, cout);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL reset_mid_no_done: %0d done pulses, want 0", seen);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int dcyc [2] = '{0, 0};
    logic [W:0] dres [2] = '{'0, '0};
    logic [W-1:0] mid_sum = '0;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 12) mid_sum = sum;
      if (done && ndone < 2) begin
        dcyc[ndone] = cyc;
        dres[ndone] = {cout, sum};
        ndone++;
        if (ndone == 1) begin a = 8'h03; b = 8'h04; end
        else start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (ndone !== 2 || dcyc[0] !== 9 || dcyc[1] !== 18)
      $display("FAIL b2b_timing: %0d pulses at %0d,%0d, want 2 at 9,18", ndone, dcyc[0], dcyc[1]);
    else passes++;
    checks++;
    if (dres[0] !== ref_add(8'h01, 8'h02, 1'b0) || dres[1] !== ref_add(8'h03, 8'h04, 1'b0))
      $display("FAIL b2b_sums: got %h,%h, want 003,007", dres[0], dres[1]);
    else passes++;
    checks++;
    if (mid_sum !== 8'h03) $display("FAIL b2b_hold: sum during 2nd op %h, want 03", mid_sum);
    else passes++;
  endtask

  task automatic test_random();
    logic [W:0] prev = '0;
    for (int i = 0; i < 1000; i++) begin
      int cyc = 1;
      int bc;
      logic [W-1:0] ra = W'($urandom);
      logic [W-1:0] rb = W'($urandom);
      logic         rc = 1'($urandom_range(0, 1));
      logic [W:0]   exp = ref_add(ra, rb, rc);
      launch(ra, rb, rc);
      if (i > 0) begin
        checks++;
        if ({cout, sum} !== prev)
          $display("FAIL rand_hold_%0d: got %b_%h, want %b_%h", i, cout, sum, prev[W], prev[W-1:0]);
        else passes++;
      end
      wait_done(cyc, bc);
      checks++;
      if (done !== 1'b1 || cyc !== W + 1 || {cout, sum} !== exp)
        $display("FAIL rand_%0d: %h+%h+%b cycle %0d got %b_%h, want %b_%h", i, ra, rb, rc, cyc, cout, sum, exp[W], exp[W-1:0]);
      else passes++;
      prev = exp;
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    repeat (12) step();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It is the addition counterpart of the team's behavioural full subtractor.
- Latches two operands on a start handshake and adds them LSB-first, one bit per clock, through a single one-bit full-adder cell and a carry flip-flop.
- Reports sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, and as the golden sequential arithmetic block for the behavioural-model library.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal: 2..32).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request to begin an addition; sampled only when busy=0
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while an addition is in progress
- done  out  1  one-cycle pulse, high on the cycle sum/cout become valid
- sum  out  WIDTH  result register, A+B+cin mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst=1 at a clock edge) forces all state to zero:
  - FSM to IDLE
  - busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry FF and bit counter all zero
- rst has priority over every other input, including mid-operation: an in-flight addition is abandoned and no done is produced.
- FSM states:
  - IDLE: busy=0, done=0. start=1 goes to SHIFT and loads:
    - shift regs <= a, b
    - carry FF <= cin
    - count <= 0
    - partial-sum reg <= 0
  - SHIFT: busy=1. Each cycle:
    - full adder on (A_sr[0], B_sr[0], carry) gives s, c
    - A_sr, B_sr shift right by one
    - s enters the partial-sum reg at the MSB, which then shifts right
    - carry <= c, count++
    - when count==WIDTH-1, go to DONE, committing the final s into bit WIDTH-1
  - DONE (one cycle): busy=0, done=1.
    - sum <= completed partial-sum reg, cout <= carry; both are visible this cycle.
    - start=1 in this cycle is accepted exactly as in IDLE and goes to SHIFT (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge 0 gives WIDTH SHIFT cycles, then done high during cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- sum/cout are registered and change only on entry to DONE (or reset). They hold the last result through IDLE and during any following SHIFT.
- start while busy=1 is ignored; a, b and cin are don't-care except on the accepting edge.
- Arithmetic: unsigned. {cout,sum} == a+b+cin exactly, in WIDTH+1 bits. No overflow flag.
- count width is clog2(WIDTH). The counter never wraps because the FSM leaves SHIFT at WIDTH-1.

Decomposition:
- Shared package arith_pkg:
  - FSM state typedef {IDLE, SHIFT, DONE}
  - localparam for counter width
- Sub-module full_adder_bit: combinational one-bit full adder (a, b, c to sum, carry), written case-based in the same behavioural style as the existing full subtractor. It is instantiated once.

Test Plan (all WIDTH=8):
- a=0x35, b=0x4A, cin=0, start pulsed 1 cycle -> busy high for 8 cycles; done=1 on cycle 9 with sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1.
- Start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at cycle 3 -> second request ignored; result sum=0x30, cout=0, one done only.
- Start 0x0F+0x01, assert rst at cycle 4 -> next cycle busy=0, sum=0, cout=0; no done pulse ever follows.
- Back-to-back: hold start=1 with 0x01+0x02, then 0x03+0x04 presented on the done cycle -> done pulses at cycles 9 and 18, with sums 0x03 and 0x07.
- Random sweep of 1000 (a, b, cin) triples -> {cout,sum} equals the reference sum a+b+cin every time; sum holds its value between done pulses.
